// File: rtl/gate_tt_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : gate_tt_pkg
//  Description : Shared types and constants for the 2-input gate truth-table
//                checker. Contains the FSM state encoding, the number of input
//                vectors and the reference truth tables of the basic gates.
//                Bit k of a table is Y for A = k[1], B = k[0].
//  Revision    : 1.0 - initial release
// ============================================================================
package gate_tt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam int VEC_COUNT = 4;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

endpackage
`default_nettype wire

// File: rtl/gate_tt_sync.sv
`default_nettype none
// ============================================================================
//  Module      : gate_tt_sync
//  Description : Two-flop synchronizer for the gate output before it is
//                sampled by the checker.
//  Ports       : clk   - clock, rising edge
//                rst_n - asynchronous active-low reset (flops clear to 0)
//                d     - asynchronous input
//                q     - synchronized output (two cycles of latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_tt_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule
`default_nettype wire

// File: rtl/gate_tt_checker.sv
`default_nettype none
// ============================================================================
//  Module      : gate_tt_checker
//  Description : Truth-table self-test for a 2-input combinational gate.
//                On start it walks the four input vectors 00,01,10,11 on
//                drive_a/drive_b, holds each for HOLD+1 cycles, samples the
//                gate output at the end of each vector into tt_out and
//                compares the result with EXP_TT.
//  Parameters  : EXP_TT        - expected truth table (default NOR)
//                SETTLE_CYCLES - extra hold cycles per vector, 0..15
//  Ports       : clk, rst_n    - clock / asynchronous active-low reset
//                start         - one-cycle test request (IDLE only)
//                abort         - synchronous cancel, no done pulse
//                gate_y        - output of the gate under test
//                drive_a/_b    - inputs to the gate under test
//                busy          - test in progress
//                done          - one-cycle result-valid pulse
//                pass          - tt_out matches EXP_TT
//                tt_out        - captured truth table
//                err_mask      - tt_out ^ EXP_TT
//  Build macro : GATE_TT_SYNC_EN - inserts a 2-flop synchronizer on gate_y
//                and lengthens each vector by two cycles to cover it.
//  Revision    : 1.0 - initial release
// ============================================================================
module gate_tt_checker
  import gate_tt_pkg::*;
#(
  parameter logic [3:0] EXP_TT        = TT_NOR,
  parameter int         SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_y,
  output logic       drive_a,
  output logic       drive_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] tt_out,
  output logic [3:0] err_mask
);

  logic w_y_s;

`ifdef GATE_TT_SYNC_EN
  // The synchronizer delays Y by two cycles, so each vector is held two
  // cycles longer to keep the sample inside the settled window.
  localparam int c_hold  = SETTLE_CYCLES + 2;
  // HOLD can reach 17 here, which needs one more counter bit.
  localparam int c_cnt_w = 5;

  gate_tt_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (gate_y),
    .q     (w_y_s)
  );
`else
  localparam int c_hold  = SETTLE_CYCLES;
  localparam int c_cnt_w = 4;

  assign w_y_s = gate_y;
`endif

  localparam logic [c_cnt_w-1:0] c_hold_v = c_cnt_w'(c_hold);
  localparam logic [1:0]         c_last_v = 2'(VEC_COUNT - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [1:0]           r_idx;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [3:0]           r_tt;
  logic                 r_pass;
  logic [3:0]           r_err;

  logic                 w_cnt_hit;
  logic                 w_last;
  logic                 w_accept;
  logic [3:0]           w_tt_next;

  assign w_cnt_hit = (r_cnt == c_hold_v);
  assign w_last    = (r_idx == c_last_v) && w_cnt_hit;
  assign w_accept  = (r_state == ST_IDLE) && start && !abort;

  // Table with the current vector's sample merged in; on the final sample
  // this is what pass/err_mask are computed from.
  always_comb begin
    w_tt_next        = r_tt;
    w_tt_next[r_idx] = w_y_s;
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_last) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    drive_a = 1'b0;
    drive_b = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (r_state)
      ST_RUN: begin
        {drive_a, drive_b} = r_idx;
        busy               = 1'b1;
      end
      ST_DONE: begin
        // An abort landing in the DONE cycle cancels the result, so the
        // pulse is suppressed rather than reporting results being cleared.
        done = !abort;
      end
      default: begin
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Vector sequencing and result capture
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= 2'd0;
      r_cnt  <= '0;
      r_tt   <= 4'b0000;
      r_pass <= 1'b0;
      r_err  <= 4'b0000;
    end else if (w_accept) begin
      r_idx  <= 2'd0;
      r_cnt  <= '0;
      r_tt   <= 4'b0000;
      r_pass <= 1'b0;
      r_err  <= 4'b0000;
    end else if ((r_state != ST_IDLE) && abort) begin
      // Partial table stays visible for debug; verdict is cleared.
      r_idx  <= 2'd0;
      r_cnt  <= '0;
      r_pass <= 1'b0;
      r_err  <= 4'b0000;
    end else if (r_state == ST_RUN) begin
      if (w_cnt_hit) begin
        r_tt  <= w_tt_next;
        r_cnt <= '0;
        // Wraps to 0 on the last vector, which coincides with leaving RUN.
        r_idx <= r_idx + 2'd1;
        if (w_last) begin
          r_pass <= (w_tt_next == EXP_TT);
          r_err  <= w_tt_next ^ EXP_TT;
        end
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign tt_out   = r_tt;
  assign pass     = r_pass;
  assign err_mask = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gate_tt_checker.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_gate_tt_checker
//  Description : Self-checking bench for gate_tt_checker. A behavioural gate
//                model (a 4-bit truth table indexed by {A,B}) answers the
//                checker's drives. Expected results are queued when a start
//                is issued and popped when done is observed.
//                u_dut : EXP_TT = NOR, SETTLE_CYCLES = 2
//                u_dut0: EXP_TT = XOR, SETTLE_CYCLES = 0
//  Build macro : GATE_TT_SYNC_EN - latencies follow the synchronized build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_gate_tt_checker;
  import gate_tt_pkg::*;

  localparam int c_settle  = 2;
  localparam int c_settle0 = 0;
`ifdef GATE_TT_SYNC_EN
  localparam int c_hold  = c_settle + 2;
  localparam int c_hold0 = c_settle0 + 2;
`else
  localparam int c_hold  = c_settle;
  localparam int c_hold0 = c_settle0;
`endif
  localparam int c_lat  = 4 * (c_hold + 1) + 1;
  localparam int c_lat0 = 4 * (c_hold0 + 1) + 1;

  typedef struct packed {
    logic [3:0] tt;
    logic       pass;
    logic [3:0] err;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic start0 = 1'b0;

  logic       drive_a, drive_b, busy, done, pass;
  logic [3:0] tt_out, err_mask;
  logic       drive_a0, drive_b0, busy0, done0, pass0;
  logic [3:0] tt_out0, err_mask0;

  logic [3:0] gate_tt  = TT_NOR;
  logic [3:0] gate_tt0 = TT_XOR;
  logic       gate_y, gate_y0;

  assign gate_y  = gate_tt[{drive_a, drive_b}];
  assign gate_y0 = gate_tt0[{drive_a0, drive_b0}];

  exp_t exp_q[$];
  int   checks    = 0;
  int   failures  = 0;
  int   done_cnt  = 0;
  int   done0_cnt = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done === 1'b1)  done_cnt++;
    if (done0 === 1'b1) done0_cnt++;
  end

  gate_tt_checker #(
    .EXP_TT        (TT_NOR),
    .SETTLE_CYCLES (c_settle)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .gate_y   (gate_y),
    .drive_a  (drive_a),
    .drive_b  (drive_b),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .tt_out   (tt_out),
    .err_mask (err_mask)
  );

  gate_tt_checker #(
    .EXP_TT        (TT_XOR),
    .SETTLE_CYCLES (c_settle0)
  ) u_dut0 (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start0),
    .abort    (1'b0),
    .gate_y   (gate_y0),
    .drive_a  (drive_a0),
    .drive_b  (drive_b0),
    .busy     (busy0),
    .done     (done0),
    .pass     (pass0),
    .tt_out   (tt_out0),
    .err_mask (err_mask0)
  );

  function automatic exp_t model(input logic [3:0] g_tt, input logic [3:0] e_tt);
    exp_t r;
    r.tt   = g_tt;
    r.pass = (g_tt == e_tt);
    r.err  = g_tt ^ e_tt;
    return r;
  endfunction

  // Called just after a negedge; returns at the negedge of cycle E0+1.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // lat = cycle index (1 = first cycle after the accepting edge) of done, -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      if (done === 1'b1) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_done0(output int lat);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      if (done0 === 1'b1) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({drive_a, drive_b, busy, done, pass} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl: drive=%b%b busy=%b done=%b pass=%b, want all 0", drive_a, drive_b, busy, done, pass);
    end
    checks++;
    if (tt_out !== 4'b0000 || err_mask !== 4'b0000) begin
      failures++;
      $display("FAIL reset_data: tt_out=%b err_mask=%b, want 0000/0000", tt_out, err_mask);
    end
    checks++;
    if ({drive_a0, drive_b0, busy0, done0, pass0, tt_out0, err_mask0} !== 13'b0) begin
      failures++;
      $display("FAIL reset_dut0: busy=%b done=%b tt_out=%b err_mask=%b, want all 0", busy0, done0, tt_out0, err_mask0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy=%b, want 0", busy);
    end
  endtask

  task automatic test_nor_pass();
    exp_t e;
    int   vec;
    gate_tt = TT_NOR;
    exp_q.push_back(model(TT_NOR, TT_NOR));
    pulse_start();
    for (int n = 1; n < c_lat; n++) begin
      vec = (n - 1) / (c_hold + 1);
      checks++;
      if ({drive_a, drive_b} !== vec[1:0] || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL nor_seq cycle %0d: drive=%b%b busy=%b done=%b, want drive=%0d busy=1 done=0",
                 n, drive_a, drive_b, busy, done, vec);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0 || {drive_a, drive_b} !== 2'b00) begin
      failures++;
      $display("FAIL nor_done cycle %0d: done=%b busy=%b drive=%b%b, want done=1 busy=0 drive=00",
               c_lat, done, busy, drive_a, drive_b);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL nor_result: scoreboard empty, want one entry");
    end else begin
      e = exp_q.pop_front();
      if (tt_out !== e.tt || pass !== e.pass || err_mask !== e.err) begin
        failures++;
        $display("FAIL nor_result: tt=%b pass=%b err=%b, want tt=%b pass=%b err=%b",
                 tt_out, pass, err_mask, e.tt, e.pass, e.err);
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || tt_out !== 4'b0001 || pass !== 1'b1) begin
      failures++;
      $display("FAIL nor_hold: done=%b tt=%b pass=%b, want done=0 tt=0001 pass=1", done, tt_out, pass);
    end
  endtask

  task automatic test_nand_fail();
    exp_t e;
    int   lat;
    gate_tt = TT_NAND;
    exp_q.push_back(model(TT_NAND, TT_NOR));
    pulse_start();
    wait_done(lat);
    checks++;
    if (lat !== c_lat) begin
      failures++;
      $display("FAIL nand_latency: done at cycle %0d, want %0d", lat, c_lat);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL nand_result: scoreboard empty, want one entry");
    end else begin
      e = exp_q.pop_front();
      if (tt_out !== e.tt || pass !== e.pass || err_mask !== e.err) begin
        failures++;
        $display("FAIL nand_result: tt=%b pass=%b err=%b, want tt=%b pass=%b err=%b",
                 tt_out, pass, err_mask, e.tt, e.pass, e.err);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_abort();
    exp_t       e;
    int         lat;
    int         d0;
    int         nsamp;
    logic [3:0] partial;
    gate_tt = TT_NOR;
    pulse_start();
    repeat (4) @(negedge clk);
    abort = 1'b1;                    // cycle 5
    @(negedge clk);
    abort = 1'b0;
    // Samples completed by the edges ending cycles 1..4.
    nsamp   = 4 / (c_hold + 1);
    partial = 4'b0000;
    for (int k = 0; k < nsamp; k++) partial[k] = gate_tt[k];
    checks++;
    if (busy !== 1'b0 || {drive_a, drive_b} !== 2'b00 || pass !== 1'b0 || err_mask !== 4'b0000) begin
      failures++;
      $display("FAIL abort_idle: busy=%b drive=%b%b pass=%b err=%b, want 0/00/0/0000",
               busy, drive_a, drive_b, pass, err_mask);
    end
    checks++;
    if (tt_out !== partial) begin
      failures++;
      $display("FAIL abort_partial: tt=%b, want %b", tt_out, partial);
    end
    d0 = done_cnt;
    repeat (c_lat + 4) @(negedge clk);
    checks++;
    if (done_cnt !== d0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_nodone: done pulses=%0d busy=%b, want 0 and 0", done_cnt - d0, busy);
    end
    // Full run after the abort, then abort landing in the DONE cycle.
    exp_q.push_back(model(TT_NOR, TT_NOR));
    pulse_start();
    wait_done(lat);
    checks++;
    if (lat !== c_lat) begin
      failures++;
      $display("FAIL abort_rerun_latency: done at cycle %0d, want %0d", lat, c_lat);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL abort_rerun_result: scoreboard empty, want one entry");
    end else begin
      e = exp_q.pop_front();
      if (tt_out !== e.tt || pass !== e.pass || err_mask !== e.err) begin
        failures++;
        $display("FAIL abort_rerun_result: tt=%b pass=%b err=%b, want tt=%b pass=%b err=%b",
                 tt_out, pass, err_mask, e.tt, e.pass, e.err);
      end
    end
    abort = 1'b1;
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL abort_in_done_pulse: done=%b, want 0", done);
    end
    @(negedge clk);
    abort = 1'b0;
    checks++;
    if (pass !== 1'b0 || err_mask !== 4'b0000 || tt_out !== 4'b0001) begin
      failures++;
      $display("FAIL abort_in_done_clear: pass=%b err=%b tt=%b, want 0/0000/0001", pass, err_mask, tt_out);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   lat;
    int   d0;
    gate_tt = TT_NOR;
    d0 = done_cnt;
    exp_q.push_back(model(TT_NOR, TT_NOR));
    pulse_start();                   // now in cycle 1
    repeat (2) @(negedge clk);
    start = 1'b1;                    // cycle 3, busy: ignored
    @(negedge clk);
    start = 1'b0;
    repeat (c_lat - 4) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_done: done=%b at cycle %0d, want 1", done, c_lat);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL b2b_first_result: scoreboard empty, want one entry");
    end else begin
      e = exp_q.pop_front();
      if (tt_out !== e.tt || pass !== e.pass || err_mask !== e.err) begin
        failures++;
        $display("FAIL b2b_first_result: tt=%b pass=%b err=%b, want tt=%b pass=%b err=%b",
                 tt_out, pass, err_mask, e.tt, e.pass, e.err);
      end
    end
    start = 1'b1;                    // DONE cycle: ignored
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_start_in_done: busy=%b, want 0", busy);
    end
    gate_tt = TT_XOR;
    exp_q.push_back(model(TT_XOR, TT_NOR));
    pulse_start();                   // cycle c_lat+1: accepted
    checks++;
    if (busy !== 1'b1 || {drive_a, drive_b} !== 2'b00 || done_cnt !== d0 + 1) begin
      failures++;
      $display("FAIL b2b_second_accept: busy=%b drive=%b%b done pulses=%0d, want 1/00/1",
               busy, drive_a, drive_b, done_cnt - d0);
    end
    wait_done(lat);
    checks++;
    if (lat !== c_lat) begin
      failures++;
      $display("FAIL b2b_second_latency: done at cycle %0d, want %0d", lat, c_lat);
    end
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL b2b_second_result: scoreboard empty, want one entry");
    end else begin
      e = exp_q.pop_front();
      if (tt_out !== e.tt || pass !== e.pass || err_mask !== e.err) begin
        failures++;
        $display("FAIL b2b_second_result: tt=%b pass=%b err=%b, want tt=%b pass=%b err=%b",
                 tt_out, pass, err_mask, e.tt, e.pass, e.err);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int d0;
    gate_tt = TT_NOR;
    d0 = done_cnt;
    pulse_start();
    repeat (6) @(negedge clk);       // cycle 7
    checks++;
    if (busy !== 1'b1 || tt_out !== 4'b0001) begin
      failures++;
      $display("FAIL rstmid_pre: busy=%b tt=%b, want 1/0001", busy, tt_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({drive_a, drive_b, busy, done, pass} !== 5'b0 || tt_out !== 4'b0000 || err_mask !== 4'b0000) begin
      failures++;
      $display("FAIL rstmid_async: drive=%b%b busy=%b done=%b pass=%b tt=%b err=%b, want all 0",
               drive_a, drive_b, busy, done, pass, tt_out, err_mask);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < c_lat + 2; n++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || {drive_a, drive_b} !== 2'b00) begin
        failures++;
        $display("FAIL rstmid_idle cycle %0d: busy=%b drive=%b%b, want 0/00", n, busy, drive_a, drive_b);
      end
    end
    checks++;
    if (done_cnt !== d0) begin
      failures++;
      $display("FAIL rstmid_nodone: done pulses=%0d, want 0", done_cnt - d0);
    end
  endtask

  task automatic test_hold0();
    exp_t e;
    int   lat;
    for (int t = 0; t < 2; t++) begin
      gate_tt0 = (t == 0) ? TT_XOR : TT_AND;
      exp_q.push_back(model(gate_tt0, TT_XOR));
      start0 = 1'b1;
      @(negedge clk);
      start0 = 1'b0;
      wait_done0(lat);
      checks++;
      if (lat !== c_lat0) begin
        failures++;
        $display("FAIL hold0_latency run %0d: done at cycle %0d, want %0d", t, lat, c_lat0);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL hold0_result run %0d: scoreboard empty, want one entry", t);
      end else begin
        e = exp_q.pop_front();
        if (tt_out0 !== e.tt || pass0 !== e.pass || err_mask0 !== e.err) begin
          failures++;
          $display("FAIL hold0_result run %0d: tt=%b pass=%b err=%b, want tt=%b pass=%b err=%b",
                   t, tt_out0, pass0, err_mask0, e.tt, e.pass, e.err);
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_nor_pass();
    test_nand_fail();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_hold0();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
